alu_seq: RTL and testbench

Parametrised sequential ALU, the next generation of the team's 8-bit combinational ALU. It keeps the same 3-bit mode encoding for the five logic and arithmetic operations and adds a start/busy/done handshake, registered result and flags, and multi-cycle shift and multiply modes. It sits between a controller that issues one operation at a time and a register file that captures `out` on `done`.

---
 rtl/alu_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a start/busy/done handshake.
// Results and flags are registered. Shifts and multiply take several cycles.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry
);

    localparam logic [2:0] M_ADD = 3'b000;
    localparam logic [2:0] M_SUB = 3'b001;
    localparam logic [2:0] M_AND = 3'b010;
    localparam logic [2:0] M_OR  = 3'b011;
    localparam logic [2:0] M_XOR = 3'b100;
    localparam logic [2:0] M_SHL = 3'b101;
    localparam logic [2:0] M_SHR = 3'b110;
    localparam logic [2:0] M_MUL = 3'b111;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CMAX = CW'(WIDTH);
    localparam logic [WIDTH-1:0] WMAX = WIDTH'(WIDTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2:0]         mode_r;
    logic               pend;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic               sc;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   res;
    logic               rc;
    logic [CW-1:0]      nsh;
    logic               is_shift;

    // Single-cycle result, computed from the latched operands.
    always_comb begin
        sum  = {1'b0, a_r} + {1'b0, b_r};
        diff = {1'b0, a_r} - {1'b0, b_r};
        res  = a_r;
        rc   = 1'b0;
        case (mode_r)
            M_ADD: begin
                res = sum[WIDTH-1:0];
                rc  = sum[WIDTH];
            end
            M_SUB: begin
                res = diff[WIDTH-1:0];
                rc  = diff[WIDTH];
            end
            M_AND:   res = a_r & b_r;
            M_OR:    res = a_r | b_r;
            M_XOR:   res = a_r ^ b_r;
            default: res = a_r;
        endcase
    end

    always_comb begin
        nsh      = (B > WMAX) ? CMAX : B[CW-1:0];
        is_shift = (mode == M_SHL) || (mode == M_SHR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            out    <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            mode_r <= '0;
            pend   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            sc     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pend) begin
                        out   <= res;
                        zero  <= (res == '0);
                        carry <= rc;
                        done  <= 1'b1;
                        pend  <= 1'b0;
                    end
                    if (start) begin
                        a_r    <= A;
                        b_r    <= B;
                        mode_r <= mode;
                        if (mode == M_MUL) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            cnt   <= CMAX;
                            acc   <= '0;
                            mcand <= {{WIDTH{1'b0}}, A};
                        end else if (is_shift && nsh != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            cnt   <= nsh;
                            acc   <= {{WIDTH{1'b0}}, A};
                            sc    <= 1'b0;
                        end else begin
                            pend <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        // All steps done: publish the working result.
                        out   <= acc[WIDTH-1:0];
                        zero  <= (acc[WIDTH-1:0] == '0);
                        carry <= (mode_r == M_MUL) ?
                                 (|acc[2*WIDTH-1:WIDTH]) : sc;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (mode_r == M_MUL) begin
                            if (b_r[0])
                                acc <= acc + mcand;
                            mcand <= mcand << 1;
                            b_r   <= b_r >> 1;
                        end else if (mode_r == M_SHL) begin
                            sc <= acc[WIDTH-1];
                            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b0};
                        end else begin
                            sc <= acc[0];
                            acc[WIDTH-1:0] <= {1'b0, acc[WIDTH-1:1]};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq (WIDTH=8).
// Expected results are queued on issue and checked when done pulses.
module tb_alu_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] mode;
    logic       busy;
    logic       done;
    logic [7:0] out;
    logic       zero;
    logic       carry;

    typedef struct {
        logic [7:0] o;
        logic       z;
        logic       c;
        int         lat;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .mode  (mode),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .zero  (zero),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] eo, input logic ez,
                        input logic ec, input int lat);
        exp_t e;
        e.o   = eo;
        e.z   = ez;
        e.c   = ec;
        e.lat = lat;
        e.acc = cyc + 1;
        q.push_back(e);
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
            return;
        end
        e = q.pop_front();
        chk({tag, "_out"}, {24'd0, out}, {24'd0, e.o});
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, e.z});
        chk({tag, "_carry"}, {31'd0, carry}, {31'd0, e.c});
        chk({tag, "_lat"}, cyc - e.acc, e.lat);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        if (!done) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            if (q.size() != 0) void'(q.pop_front());
        end else begin
            check_pop(tag);
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic [2:0] m,
                          input logic [7:0] eo, input logic ez,
                          input logic ec, input int lat);
        push(eo, ez, ec, lat);
        A = a;
        B = b;
        mode = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (lat > 1)
            chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        wait_done(tag);
    endtask

    logic [7:0] b2b_o[5] = '{8'h03, 8'h01, 8'h00, 8'h03, 8'h03};
    logic       b2b_z[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int dcount;
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        mode = '0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out", {24'd0, out}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_carry", {31'd0, carry}, 32'd0);
        rst = 1'b0;
        tick();

        // back-to-back single-cycle ops
        for (int i = 0; i < 5; i++) begin
            push(b2b_o[i], b2b_z[i], 1'b0, 1);
            A = 8'h02;
            B = 8'h01;
            mode = 3'(i);
            start = 1'b1;
            tick();
            chk("b2b_busy", {31'd0, busy}, 32'd0);
            if (i > 0) begin
                chk("b2b_done", {31'd0, done}, 32'd1);
                check_pop("b2b");
            end
        end
        start = 1'b0;
        tick();
        chk("b2b_done_last", {31'd0, done}, 32'd1);
        check_pop("b2b");
        tick();
        chk("b2b_done_low", {31'd0, done}, 32'd0);

        run_op("add_ovf", 8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b1, 1);
        run_op("sub_brw", 8'h01, 8'h02, 3'b001, 8'hFF, 1'b0, 1'b1, 1);
        run_op("shl3", 8'h81, 8'h03, 3'b101, 8'h08, 1'b0, 1'b0, 4);
        run_op("shr9", 8'h81, 8'h09, 3'b110, 8'h00, 1'b1, 1'b1, 9);
        run_op("shl0", 8'h81, 8'h00, 3'b101, 8'h81, 1'b0, 1'b0, 1);
        run_op("mul_hi", 8'h10, 8'h20, 3'b111, 8'h00, 1'b1, 1'b1, 9);

        // MUL with a stray start in its third cycle
        push(8'h2D, 1'b0, 1'b0, 9);
        A = 8'h0F;
        B = 8'h03;
        mode = 3'b111;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        A = 8'hFF;
        B = 8'hFF;
        mode = 3'b000;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_busy", {31'd0, busy}, 32'd1);
        wait_done("mul_ign");
        tick();
        chk("ign_no_queue", {31'd0, done}, 32'd0);
        tick();
        chk("ign_no_queue2", {31'd0, done}, 32'd0);

        // reset in the middle of a MUL
        A = 8'h10;
        B = 8'h20;
        mode = 3'b111;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mrst_out", {24'd0, out}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_zero", {31'd0, zero}, 32'd0);
        chk("mrst_carry", {31'd0, carry}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) dcount++;
        end
        chk("mrst_no_done", dcount, 32'd0);
        run_op("post_rst_add", 8'h02, 8'h01, 3'b000, 8'h03, 1'b0, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
